cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Drives the `step` input of the instruction decoder and latches the instruction register (IR).
- Paces every M-cycle with a T-state counter and honours memory wait states.
- Resolves conditional branches (JR cc etc.) from the flags.
- Issues the commit strobe that the register file, ALU flags and PC use to latch decoder-selected writes.

Parameters:
- T_PER_M, 4, T-states per M-cycle (min 2); `m_end` fires on the last T-state.
- MAX_STEP, 7, highest legal step; reaching it without `done` locks the core.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- db_in  in  8  data bus input; opcode source at fetch
- mem_wait  in  1  memory not ready; holds the last T-state
- flags  in  4  {Z,N,H,C} from flag register
- dec_done  in  1  decoder `done`
- dec_is_cond  in  1  decoder `is_cond`
- dec_next_cond  in  3  decoder `next_cond`
- irq_pending  in  1  wake request (used only with SEQ_HALT_EN)
- ir  out  8  instruction register, feeds decoder opcode
- step  out  3  current step, feeds decoder step
- fetch  out  1  forced opcode-fetch cycle; datapath uses s_ab=PC, inc PC
- t_state  out  2  current T-state index
- m_end  out  1  one-clock commit strobe on the last T-state of a non-waiting M-cycle
- halted  out  1  in HALT state
- locked  out  1  in LOCK state (step overflow)

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low, `rst_n`.
- Reset values:
  - state=FETCH, ir=8'h00, step=0, t_state=0.
  - m_end=0, fetch=1, halted=0, locked=0.
- T-state counter:
  - Increments each clk from 0 to T_PER_M-1, then wraps to 0.
  - On the last T-state with mem_wait=1: counter holds and m_end=0.
  - m_end = (t_state==T_PER_M-1) && !mem_wait && state!=LOCK && state!=HALT. It is combinational and registered-safe.
  - In HALT and LOCK the counter is held at 0.
- FETCH (entered only out of reset or HALT exit):
  - fetch=1, step=0.
  - At m_end: ir<=db_in, state<=EXEC.
- EXEC: step and state updates occur only at m_end, in priority order:
  1. dec_done=1: ir<=db_in (overlapped fetch of the next opcode) and step<=0.
     - With SEQ_HALT_EN and ir==8'h76: state<=HALT, step<=0, and ir is not reloaded.
  2. dec_is_cond=1 and cc not met: step<=dec_next_cond.
  3. step==MAX_STEP: state<=LOCK.
  4. Otherwise: step<=step+1.
- Condition code:
  - cc=ir[4:3]: 0 NZ (!Z), 1 Z (Z), 2 NC (!C), 3 C (C).
  - flags are sampled at m_end of the evaluating step.
  - dec_is_cond=1 with cc met: normal step+1.
- LOCK:
  - locked=1 and step frozen; all inputs ignored until rst_n.
  - Intended for decoder holes (illegal opcodes).
- Simultaneous events:
  - dec_done and dec_is_cond both high: done wins.
  - mem_wait high on a non-last T-state: no effect.
- Reset mid-M-cycle: all state clears immediately. The first M-cycle after release is FETCH at t_state 0.
- Between m_end strobes, ir and step are stable.

Optional Feature:
- Macro: SEQ_HALT_EN.
- With the macro defined:
  - Opcode 8'h76 at dec_done enters HALT: halted=1, m_end suppressed, t_state=0.
  - irq_pending=1, sampled each clk, moves HALT to FETCH on the next clk.
  - HALT exit does not reload ir; the FETCH cycle reloads it.
- Without the macro:
  - HALT state is absent, irq_pending is unconnected internally, halted is tied 0.
  - 8'h76 is sequenced like any other opcode.

Test Plan:
1. Reset and first fetch: rst_n low, then high; db_in=8'h01, mem_wait=0.
   - Expected: fetch=1 for 4 clks, m_end on clk 4, ir=8'h01, step=0, fetch=0.
2. Multi-step instruction: ir=8'h01, dec_done high only at step 2, db_in=8'h3E at that m_end.
   - Expected: step sequence 0,1,2 across 12 clks, then ir=8'h3E, step=0.
3. Wait states: mem_wait=1 for 3 clks during the last T-state of step 0.
   - Expected: t_state stays 3 for 3 extra clks, m_end appears only after mem_wait drops, step then advances to 1.
4. Conditional not taken: ir=8'h20 (JR NZ), flags Z=1, dec_is_cond=1 at step 1, dec_next_cond=4.
   - Expected: next step=4.
   - Repeat with Z=0: next step=2.
5. Step overflow: dec_done never asserted.
   - Expected: after step 7 m_end, locked=1, step stays 7, m_end never fires again; rst_n low clears locked asynchronously.
6. SEQ_HALT_EN defined: ir=8'h76 with dec_done high.
   - Expected: halted=1, no m_end for 20 clks.
   - Then irq_pending=1: next clk halted=0, fetch=1, and 4 clks later ir<=db_in.

Source files
------------

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer
//  Purpose  : Instruction sequencer. Paces M-cycles with a T-state counter,
//             honours memory wait states, latches the instruction register,
//             advances the decoder step, resolves conditional branches and
//             issues the m_end commit strobe.
//  Options  : SEQ_HALT_EN - adds a HALT state entered on opcode 8'h76 and
//             left on irq_pending. Undefined: halted is tied 0.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int T_PER_M  = 4,
    parameter int MAX_STEP = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] db_in,
    input  logic       mem_wait,
    input  logic [3:0] flags,
    input  logic       dec_done,
    input  logic       dec_is_cond,
    input  logic [2:0] dec_next_cond,
    input  logic       irq_pending,
    output logic [7:0] ir,
    output logic [2:0] step,
    output logic       fetch,
    output logic [1:0] t_state,
    output logic       m_end,
    output logic       halted,
    output logic       locked
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_LOCK  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [1:0] c_T_LAST   = 2'(T_PER_M - 1);
    localparam logic [2:0] c_MAX_STEP = 3'(MAX_STEP);
    localparam logic [7:0] c_OP_HALT  = 8'h76;

    logic [1:0] r_state;
    logic [7:0] r_ir;
    logic [2:0] r_step;
    logic [1:0] r_t;

    logic [1:0] w_state_nxt;
    logic [7:0] w_ir_nxt;
    logic [2:0] w_step_nxt;
    logic [1:0] w_t_nxt;
    logic [1:0] w_t_tick;
    logic       w_cc_met;

`ifndef SEQ_HALT_EN
    // Wake request and the N/H flags have no role in this build.
    logic w_unused_ok;
    assign w_unused_ok = ^{irq_pending, flags[2:1]};
`else
    logic w_unused_ok;
    assign w_unused_ok = ^flags[2:1];
`endif

    assign ir      = r_ir;
    assign step    = r_step;
    assign t_state = r_t;

    // Condition code from ir[4:3]: NZ, Z, NC, C  (flags = {Z,N,H,C}).
    always_comb begin
        w_cc_met = 1'b0;
        case (r_ir[4:3])
            2'd0:    w_cc_met = !flags[3];
            2'd1:    w_cc_met =  flags[3];
            2'd2:    w_cc_met = !flags[0];
            default: w_cc_met =  flags[0];
        endcase
    end

    // T-state advance while running: wrap after the last state unless memory stalls it.
    always_comb begin
        w_t_tick = r_t;
        if (r_t != c_T_LAST) begin
            w_t_tick = r_t + 2'd1;
        end else if (!mem_wait) begin
            w_t_tick = 2'd0;
        end
    end

    // State register together with the IR, step and T-state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ir    <= 8'h00;
            r_step  <= 3'd0;
            r_t     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ir    <= w_ir_nxt;
            r_step  <= w_step_nxt;
            r_t     <= w_t_nxt;
        end
    end

    // Next-state logic; IR and step only ever change on an m_end strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        w_step_nxt  = r_step;
        w_t_nxt     = r_t;
        case (r_state)
            S_FETCH: begin
                w_t_nxt = w_t_tick;
                if (m_end) begin
                    w_ir_nxt    = db_in;
                    w_step_nxt  = 3'd0;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_t_nxt = w_t_tick;
                if (m_end) begin
                    if (dec_done) begin
`ifdef SEQ_HALT_EN
                        if (r_ir == c_OP_HALT) begin
                            w_state_nxt = S_HALT;
                            w_step_nxt  = 3'd0;
                        end else begin
                            w_ir_nxt   = db_in;
                            w_step_nxt = 3'd0;
                        end
`else
                        // Overlapped fetch of the next opcode.
                        w_ir_nxt   = db_in;
                        w_step_nxt = 3'd0;
`endif
                    end else if (dec_is_cond && !w_cc_met) begin
                        w_step_nxt = dec_next_cond;
                    end else if (r_step == c_MAX_STEP) begin
                        w_state_nxt = S_LOCK;
                    end else begin
                        w_step_nxt = r_step + 3'd1;
                    end
                end
            end
            S_LOCK: begin
                w_t_nxt = 2'd0;
            end
`ifdef SEQ_HALT_EN
            S_HALT: begin
                w_t_nxt = 2'd0;
                if (irq_pending) begin
                    w_state_nxt = S_FETCH;
                end
            end
`endif
            default: begin
                w_state_nxt = S_FETCH;
                w_t_nxt     = 2'd0;
            end
        endcase
    end

    // Output decode; m_end is combinational so a stall drops it in the same cycle.
    always_comb begin
        fetch  = (r_state == S_FETCH);
        locked = (r_state == S_LOCK);
`ifdef SEQ_HALT_EN
        halted = (r_state == S_HALT);
`else
        halted = 1'b0;
`endif
        m_end  = (r_t == c_T_LAST) && !mem_wait &&
                 ((r_state == S_FETCH) || (r_state == S_EXEC));
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_sequencer
//  Purpose  : Self-checking bench for cpu_sequencer: directed scenarios with
//             literal expectations, then randomized traffic compared every
//             cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam int T_PER_M  = 4;
    localparam int MAX_STEP = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] db_in = 8'h00;
    logic       mem_wait = 1'b0;
    logic [3:0] flags = 4'h0;
    logic       dec_done = 1'b0;
    logic       dec_is_cond = 1'b0;
    logic [2:0] dec_next_cond = 3'd0;
    logic       irq_pending = 1'b0;

    logic [7:0] ir;
    logic [2:0] step;
    logic       fetch;
    logic [1:0] t_state;
    logic       m_end;
    logic       halted;
    logic       locked;

    int errs   = 0;
    int checks = 0;

    cpu_sequencer #(.T_PER_M(T_PER_M), .MAX_STEP(MAX_STEP)) dut (
        .clk(clk), .rst_n(rst_n), .db_in(db_in), .mem_wait(mem_wait),
        .flags(flags), .dec_done(dec_done), .dec_is_cond(dec_is_cond),
        .dec_next_cond(dec_next_cond), .irq_pending(irq_pending),
        .ir(ir), .step(step), .fetch(fetch), .t_state(t_state),
        .m_end(m_end), .halted(halted), .locked(locked)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode is one of "fetch", "exec", "lock", "halt".
    string      md_mode = "fetch";
    int         md_t    = 0;
    int         md_step = 0;
    logic [7:0] md_ir   = 8'h00;

    function automatic bit md_mend();
        return (md_t == T_PER_M - 1) && !mem_wait &&
               (md_mode == "fetch" || md_mode == "exec");
    endfunction

    function automatic bit md_cc();
        bit z = flags[3];
        bit c = flags[0];
        case (md_ir[4:3])
            2'd0:    return !z;
            2'd1:    return z;
            2'd2:    return !c;
            default: return c;
        endcase
    endfunction

    task automatic md_reset();
        md_mode = "fetch"; md_t = 0; md_step = 0; md_ir = 8'h00;
    endtask

    task automatic md_clock();
        bit me;
        if (!rst_n) begin md_reset(); return; end
        me = md_mend();
        if (md_mode == "halt") begin
            if (irq_pending) md_mode = "fetch";
            return;
        end
        if (md_mode == "lock") return;
        if (md_t < T_PER_M - 1) md_t++;
        else if (!mem_wait) md_t = 0;
        if (!me) return;
        if (md_mode == "fetch") begin
            md_ir = db_in; md_step = 0; md_mode = "exec";
        end else if (dec_done) begin
`ifdef SEQ_HALT_EN
            if (md_ir == 8'h76) begin md_mode = "halt"; md_step = 0; end
            else begin md_ir = db_in; md_step = 0; end
`else
            md_ir = db_in; md_step = 0;
`endif
        end else if (dec_is_cond && !md_cc()) begin
            md_step = int'(dec_next_cond);
        end else if (md_step == MAX_STEP) begin
            md_mode = "lock";
        end else begin
            md_step++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("t_state", 32'(t_state), 32'(md_t));
        chk("step",    32'(step),    32'(md_step));
        chk("ir",      32'(ir),      32'(md_ir));
        chk("fetch",   32'(fetch),   32'(md_mode == "fetch"));
        chk("locked",  32'(locked),  32'(md_mode == "lock"));
        chk("halted",  32'(halted),  32'(md_mode == "halt"));
        chk("m_end",   32'(m_end),   32'(md_mend()));
    endtask

    // One clock: apply inputs at negedge, compare, then advance model at posedge.
    task automatic cyc(input logic r, input logic [7:0] d, input logic w,
                       input logic [3:0] f, input logic dn, input logic ic,
                       input logic [2:0] nc, input logic irq);
        @(negedge clk);
        rst_n = r; db_in = d; mem_wait = w; flags = f; dec_done = dn;
        dec_is_cond = ic; dec_next_cond = nc; irq_pending = irq;
        #1;
        if (!rst_n) md_reset();
        check_model();
        @(posedge clk);
        md_clock();
        #1;
    endtask

    // One full M-cycle with no wait states.
    task automatic mcyc(input logic [7:0] d, input logic [3:0] f, input logic dn,
                        input logic ic, input logic [2:0] nc);
        for (int i = 0; i < T_PER_M; i++) cyc(1'b1, d, 1'b0, f, dn, ic, nc, 1'b0);
    endtask

    initial begin
        // Reset and first fetch
        cyc(1'b0, 8'h01, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc(1'b0, 8'h01, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("rst_fetch", 32'(fetch), 32'd1);
        chk("rst_ir", 32'(ir), 32'h00);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_t", 32'(t_state), 32'd0);
        chk("rst_mend", 32'(m_end), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h01, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("fetch_t3", 32'(t_state), 32'd3);
        chk("fetch_mend", 32'(m_end), 32'd1);
        cyc(1'b1, 8'h01, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("fetch_ir", 32'(ir), 32'h01);
        chk("fetch_done", 32'(fetch), 32'd0);
        chk("fetch_step", 32'(step), 32'd0);

        // Multi-step instruction, done at step 2
        mcyc(8'h00, 4'h0, 1'b0, 1'b0, 3'd0);
        chk("ms_step1", 32'(step), 32'd1);
        mcyc(8'h00, 4'h0, 1'b0, 1'b0, 3'd0);
        chk("ms_step2", 32'(step), 32'd2);
        mcyc(8'h3E, 4'h0, 1'b1, 1'b0, 3'd0);
        chk("ms_ir", 32'(ir), 32'h3E);
        chk("ms_step0", 32'(step), 32'd0);

        // Wait states on the last T-state of step 0
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("ws_t_held", 32'(t_state), 32'd3);
        chk("ws_no_mend", 32'(m_end), 32'd0);
        chk("ws_step_held", 32'(step), 32'd0);
        cyc(1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("ws_step1", 32'(step), 32'd1);
        chk("ws_t_wrap", 32'(t_state), 32'd0);

        // Conditional JR NZ: not taken with Z=1, taken with Z=0
        mcyc(8'h20, 4'h0, 1'b1, 1'b0, 3'd0);
        chk("jr_ir", 32'(ir), 32'h20);
        mcyc(8'h00, 4'h0, 1'b0, 1'b0, 3'd0);
        mcyc(8'h00, 4'h8, 1'b0, 1'b1, 3'd4);
        chk("jr_not_taken", 32'(step), 32'd4);
        mcyc(8'h20, 4'h0, 1'b1, 1'b0, 3'd0);
        mcyc(8'h00, 4'h0, 1'b0, 1'b0, 3'd0);
        mcyc(8'h00, 4'h0, 1'b0, 1'b1, 3'd4);
        chk("jr_taken", 32'(step), 32'd2);
        // done beats is_cond
        mcyc(8'h55, 4'h8, 1'b1, 1'b1, 3'd6);
        chk("done_wins_step", 32'(step), 32'd0);
        chk("done_wins_ir", 32'(ir), 32'h55);

        // Step overflow into LOCK
        for (int i = 0; i < MAX_STEP + 1; i++) mcyc(8'h00, 4'h0, 1'b0, 1'b0, 3'd0);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_step", 32'(step), 32'd7);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'hFF, 1'b0, 4'hF, 1'b1, 1'b1, 3'd1, 1'b1);
        chk("lock_hold", 32'(step), 32'd7);
        chk("lock_t0", 32'(t_state), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("lock_cleared", 32'(locked), 32'd0);

`ifdef SEQ_HALT_EN
        // HALT and wake
        mcyc(8'h76, 4'h0, 1'b0, 1'b0, 3'd0);
        chk("halt_ir", 32'(ir), 32'h76);
        mcyc(8'h11, 4'h0, 1'b1, 1'b0, 3'd0);
        chk("halt_in", 32'(halted), 32'd1);
        chk("halt_ir_kept", 32'(ir), 32'h76);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'h11, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("halt_stay", 32'(halted), 32'd1);
        cyc(1'b1, 8'h11, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        chk("wake_halted", 32'(halted), 32'd0);
        chk("wake_fetch", 32'(fetch), 32'd1);
        mcyc(8'h5A, 4'h0, 1'b0, 1'b0, 3'd0);
        chk("wake_ir", 32'(ir), 32'h5A);
`else
        // 0x76 sequences like any other opcode
        mcyc(8'h76, 4'h0, 1'b0, 1'b0, 3'd0);
        mcyc(8'h11, 4'h0, 1'b1, 1'b0, 3'd0);
        chk("nohalt_halted", 32'(halted), 32'd0);
        chk("nohalt_ir", 32'(ir), 32'h11);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic r;
            r = ($urandom_range(149) != 0);
            cyc(r,
                (($urandom_range(7) == 0) ? 8'h76 : 8'($urandom)),
                ($urandom_range(3) == 0),
                4'($urandom),
                ($urandom_range(2) == 0),
                ($urandom_range(2) == 0),
                3'($urandom),
                ($urandom_range(9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Absolute time guard
    initial begin
        #2000000;
        errs++;
        $display("FAIL timeout: got running expected finished at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
